filter_frame_ctrl: RTL
======================

# filter_frame_ctrl

Frame sequencer for the intensity-equalisation filter path. Captures and validates the 4-word PGM header (magic, width, height, maxval), arms on `readButton`, then on `applyFilterButton` walks the frame row-major, one pixel at a time. For each pixel it reads the source, issues it to the pixel-transform datapath with the latched `filterType`, saturates the result and writes it back. It sits between the PGM reader/writer ports and the transform unit.

## Interface

- `WIDTH`, 320, pixels per row
- `HEIGHT`, 320, rows per frame
- `ADDR_W`, 17, pixel address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `readButton`  in  1  level; rising edge starts header capture
- `applyFilterButton`  in  1  level; rising edge starts frame processing
- `filterType`  in  2  transform select; sampled only at apply start
- `hdr_valid` / `hdr_ready`  in / out  1 / 1  header word handshake
- `hdr_data`  in  32  header word
- `rd_req`  out  1  source pixel read request
- `rd_addr`  out  ADDR_W  source address, row*WIDTH+col
- `rd_ack`  in  1  read completes this cycle
- `rd_data`  in  8  source pixel, valid with `rd_ack`
- `xf_valid` / `xf_ready`  out / in  1 / 1  transform issue handshake
- `xf_pixel`  out  8  pixel to transform
- `xf_type`  out  2  latched filter type
- `res_valid`  in  1  transform result strobe
- `res_data`  in  16  unsaturated transform result
- `wr_valid` / `wr_ready`  out / in  1 / 1  output write handshake
- `wr_addr`  out  ADDR_W  destination address, equal to the source address
- `wr_data`  out  8  filtered pixel
- `wr_eol`  out  1  high with `wr_valid` when col==WIDTH-1
- `busy`  out  1  high in states RD, XF, RES, WR
- `done`  out  1  high in DONE
- `error`  out  1  high in ERR

## Operation

- Button edges: one registered copy per button; edge = btn & ~btn_q. An edge in a state that does not consume it is discarded.
- States: IDLE, HDR, ARMED, RD, XF, RES, WR, DONE, ERR.
- IDLE: readButton edge -> HDR, hdr_cnt=0.
- HDR: `hdr_ready`=1. Each accepted word is stored at index hdr_cnt, and hdr_cnt increments.
  - After word 3 is accepted, check word1==WIDTH, word2==HEIGHT and 1<=word3<=255.
  - Pass -> ARMED. Fail -> ERR. Word0 (magic) is stored and not checked.
- ARMED: applyFilterButton edge -> latch `filterType` into `xf_type`, row=col=0, -> RD.
- RD: `rd_req`=1. On `rd_ack`, capture `rd_data` -> XF.
- XF: `xf_valid`=1. On `xf_ready` -> RES.
- RES: wait for `res_valid`. Capture the saturated result (see Configuration) -> WR. A `res_valid` seen outside RES is ignored.
- WR: `wr_valid`=1. On `wr_ready`:
  - col==WIDTH-1: col=0, row++.
  - Otherwise: col++.
  - Last pixel (row==HEIGHT-1, col==WIDTH-1) -> DONE; else -> RD.
- DONE and ERR: readButton edge -> HDR (new frame). applyFilterButton is ignored.
- `filterType` changes during a frame are ignored until the next apply start.
- Only one pixel is outstanding at any time. Request outputs hold stable until their handshake completes.

## Timing

- Reset values: every output 0, state IDLE, counters 0.
- Reset mid-frame aborts immediately. No further write is issued.
- All outputs are registered. A handshake input seen at edge N changes state at edge N and outputs from N+1.
- With acks/ready/res_valid asserted on the first possible cycle:
  - 4 cycles per pixel (RD, XF, RES, WR).
  - Frame = 4*WIDTH*HEIGHT cycles from the first RD to DONE.
- Button edge to state change: 1 cycle after the button goes high (edge detect register).
- Header with `hdr_valid` held high: 4 cycles in HDR, then ARMED or ERR on the next edge.

## Configuration

- `FILTER_CTRL_SAT_EN` defined: `wr_data` = (res_data > 255) ? 255 : res_data[7:0].
- `FILTER_CTRL_SAT_EN` undefined: `wr_data` = res_data[7:0] (wrap).

## Test plan

All scenarios use WIDTH=4, HEIGHT=2, with responders always ready unless stated.

1. Header {x, 4, 2, 255}, then readButton/apply pulses, identity transform -> 8 writes to addresses 0..7 with data equal to the source; `wr_eol` high at addresses 3 and 7; `done` after 32 cycles.
2. Header height word = 3 -> ERR, `error`=1. An apply edge stays in ERR. A readButton edge returns to HDR.
3. `res_data`=300 -> `wr_data`=255 with `FILTER_CTRL_SAT_EN` defined, 44 without.
4. `filterType`=2 at the apply edge, changed to 1 mid-frame -> `xf_type`=2 for all 8 issues.
5. Reset asserted in WR at pixel 5 -> all outputs 0 the same cycle. A new header plus apply completes a full 8-pixel frame.
6. `rd_ack` delayed 3 cycles and `wr_ready` delayed 2 cycles per pixel -> `rd_addr`/`wr_data` held stable; 9 cycles per pixel; no duplicate or skipped address.

Source files
------------

// File: rtl/filter_frame_ctrl_if.sv
// Handshake bundle between filter_frame_ctrl and its header source, pixel
// reader, transform unit and pixel writer.
// master: the frame controller. slave: the surrounding ports.
interface filter_frame_ctrl_if #(
   parameter int ADDR_W = 17
);
   logic              hdr_valid;
   logic              hdr_ready;
   logic [31:0]       hdr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [7:0]        rd_data;
   logic              xf_valid;
   logic              xf_ready;
   logic [7:0]        xf_pixel;
   logic [1:0]        xf_type;
   logic              res_valid;
   logic [15:0]       res_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_eol;

   modport master (
      input  hdr_valid, hdr_data, rd_ack, rd_data, xf_ready, res_valid, res_data, wr_ready,
      output hdr_ready, rd_req, rd_addr, xf_valid, xf_pixel, xf_type, wr_valid, wr_addr,
             wr_data, wr_eol
   );

   modport slave (
      output hdr_valid, hdr_data, rd_ack, rd_data, xf_ready, res_valid, res_data, wr_ready,
      input  hdr_ready, rd_req, rd_addr, xf_valid, xf_pixel, xf_type, wr_valid, wr_addr,
             wr_data, wr_eol
   );
endinterface

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the intensity-equalisation filter path.
// Captures a 4-word PGM header, arms on readButton, then walks the frame
// row-major one pixel at a time: read -> transform -> saturate -> write.
// Optional macro FILTER_CTRL_SAT_EN: clamp results above 255 to 255
// (default build wraps to the low byte).
module filter_frame_ctrl #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 320,
   parameter int ADDR_W = 17
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                readButton,
   input  logic                applyFilterButton,
   input  logic [1:0]          filterType,
   filter_frame_ctrl_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                error
);
   localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_ARMED, S_RD, S_XF, S_RES, S_WR, S_DONE, S_ERR
   } state_t;

   state_t            state, state_n;
   logic              rd_btn_q, ap_btn_q;
   logic              rd_edge, ap_edge;
   logic [1:0]        hdr_cnt;
   logic [31:0]       hdr_q [4];
   logic              hdr_acc, hdr_ok;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        pix_q, res_q, res_sat;
   logic [1:0]        type_q;
   logic              hdr_ready_q, rd_req_q, xf_valid_q, wr_valid_q, wr_eol_q;
   logic              last_pix;

   assign rd_edge  = readButton & ~rd_btn_q;
   assign ap_edge  = applyFilterButton & ~ap_btn_q;
   assign hdr_acc  = (state == S_HDR) && bus.hdr_valid && hdr_ready_q;
   // Word 3 (maxval) is checked straight off the bus as it is accepted.
   assign hdr_ok   = (hdr_q[1] == 32'(WIDTH)) && (hdr_q[2] == 32'(HEIGHT)) &&
                     (bus.hdr_data != 32'd0) && (bus.hdr_data <= 32'd255);
   assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

   // Magic and maxval are kept for visibility only; nothing downstream reads them.
   logic unused_hdr;
   assign unused_hdr = ^{hdr_q[0], hdr_q[3]};

`ifdef FILTER_CTRL_SAT_EN
   assign res_sat = (bus.res_data > 16'd255) ? 8'hFF : bus.res_data[7:0];
`else
   assign res_sat = bus.res_data[7:0];
   logic unused_res;
   assign unused_res = ^bus.res_data[15:8];
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state decode; unconsumed button edges simply fall through.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (rd_edge) state_n = S_HDR;
         S_HDR:   if (hdr_acc && hdr_cnt == 2'd3) state_n = hdr_ok ? S_ARMED : S_ERR;
         S_ARMED: if (ap_edge) state_n = S_RD;
         S_RD:    if (bus.rd_ack) state_n = S_XF;
         S_XF:    if (bus.xf_ready) state_n = S_RES;
         S_RES:   if (bus.res_valid) state_n = S_WR;
         S_WR:    if (bus.wr_ready) state_n = last_pix ? S_DONE : S_RD;
         S_DONE,
         S_ERR:   if (rd_edge) state_n = S_HDR;
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath: button history, header capture, pixel counters and data latches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_btn_q <= 1'b0;
         ap_btn_q <= 1'b0;
         hdr_cnt  <= '0;
         for (int i = 0; i < 4; i++) hdr_q[i] <= '0;
         col      <= '0;
         row      <= '0;
         addr     <= '0;
         pix_q    <= '0;
         res_q    <= '0;
         type_q   <= '0;
      end else begin
         rd_btn_q <= readButton;
         ap_btn_q <= applyFilterButton;
         if (state_n == S_HDR && state != S_HDR) begin
            hdr_cnt <= '0;
         end else if (hdr_acc) begin
            hdr_q[hdr_cnt] <= bus.hdr_data;
            hdr_cnt        <= hdr_cnt + 2'd1;
         end
         if (state == S_ARMED && ap_edge) begin
            type_q <= filterType;
            col    <= '0;
            row    <= '0;
            addr   <= '0;
         end
         if (state == S_RD && bus.rd_ack)     pix_q <= bus.rd_data;
         if (state == S_RES && bus.res_valid) res_q <= res_sat;
         // addr tracks row*WIDTH+col incrementally.
         if (state == S_WR && bus.wr_ready) begin
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Registered control outputs, decoded from the state being entered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hdr_ready_q <= 1'b0;
         rd_req_q    <= 1'b0;
         xf_valid_q  <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_eol_q    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         hdr_ready_q <= (state_n == S_HDR);
         rd_req_q    <= (state_n == S_RD);
         xf_valid_q  <= (state_n == S_XF);
         wr_valid_q  <= (state_n == S_WR);
         wr_eol_q    <= (state_n == S_WR) && (col == COL_LAST);
         busy        <= (state_n == S_RD) || (state_n == S_XF) ||
                        (state_n == S_RES) || (state_n == S_WR);
         done        <= (state_n == S_DONE);
         error       <= (state_n == S_ERR);
      end
   end

   assign bus.hdr_ready = hdr_ready_q;
   assign bus.rd_req    = rd_req_q;
   assign bus.rd_addr   = addr;
   assign bus.xf_valid  = xf_valid_q;
   assign bus.xf_pixel  = pix_q;
   assign bus.xf_type   = type_q;
   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = addr;
   assign bus.wr_data   = res_q;
   assign bus.wr_eol    = wr_eol_q;
endmodule
